// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - start/data/parity/stop serial byte transmitter
//
// Serialises one parallel word per valid/ready handshake onto a line that
// idles high. A frame is one low start bit, DATA_BITS data bits LSB first,
// an optional parity bit, then STOP_BITS high stop bits. Each bit lasts
// CLKS_PER_BIT clocks.
//
// Ports:
//   clk       clock, all logic on posedge
//   reset     synchronous, active-high
//   in_valid  producer has a word on in_data
//   in_data   word to transmit, latched on acceptance
//   in_ready  a word can be accepted this cycle
//   out       registered serial line, idles high
//   busy      frame in progress
//   done      one-cycle pulse in the last cycle of a frame
module serial_byte_tx #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        baud_q, baud_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n, sh_shift;
  logic                 par_q, par_n;
  logic                 out_q, out_n;

  logic baud_last;
  logic last_stop;
  logic accept;

  assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign last_stop = (state_q == STOP) && baud_last && (bit_q == BW'(STOP_BITS - 1));

  // The last stop cycle doubles as an acceptance window so a new start
  // bit can follow the stop bit with no idle gap.
  assign in_ready = (state_q == IDLE) || last_stop;
  assign accept   = in_valid && in_ready;
  assign done     = last_stop;
  assign busy     = (state_q != IDLE);
  assign out      = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      out_q   <= out_n;
    end
  end

  // out_n is the line value for the next cycle, so the register always
  // holds the bit belonging to the state being entered.
  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    shreg_n  = shreg_q;
    par_n    = par_q;
    out_n    = out_q;
    sh_shift = shreg_q >> 1;

    if (accept) begin
      state_n = START;
      baud_n  = '0;
      bit_n   = '0;
      shreg_n = in_data;
      par_n   = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
      out_n   = 1'b0;
    end else if (state_q != IDLE) begin
      if (!baud_last) begin
        baud_n = baud_q + CW'(1);
      end else begin
        baud_n = '0;
        case (state_q)
          START: begin
            state_n = DATA;
            bit_n   = '0;
            out_n   = shreg_q[0];
          end
          DATA: begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_n = '0;
              if (PARITY_EN != 0) begin
                state_n = PARITY;
                out_n   = par_q;
              end else begin
                state_n = STOP;
                out_n   = 1'b1;
              end
            end else begin
              bit_n   = bit_q + BW'(1);
              shreg_n = sh_shift;
              out_n   = sh_shift[0];
            end
          end
          PARITY: begin
            state_n = STOP;
            bit_n   = '0;
            out_n   = 1'b1;
          end
          STOP: begin
            out_n = 1'b1;
            if (bit_q == BW'(STOP_BITS - 1)) begin
              state_n = IDLE;
              bit_n   = '0;
            end else begin
              bit_n = bit_q + BW'(1);
            end
          end
          default: begin
            state_n = IDLE;
            bit_n   = '0;
            out_n   = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
Serial byte transmitter, the send side of the team's start/8-data/stop serial line protocol. It accepts a parallel word over a valid/ready handshake and serialises it: one low start bit, data bits LSB first, an optional parity bit, then one or more high stop bits. Its output drives the serial line that feeds the team's serial receiver/datapath FSM. The default configuration (one clock per bit, 8 data bits, no parity, 1 stop bit) is bit-exact with that receiver's expected line format.

Parameters:
DATA_BITS, 8, number of data bits per frame (valid range 1..16)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 1, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (valid range 1..2)
CLKS_PER_BIT, 1, clock cycles per serial bit (valid range >= 1)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_BITS  word to transmit; sampled only on acceptance
in_ready  output  1  transmitter can accept a word this cycle
out  output  1  serial line; idles high; registered
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse marking the last cycle of a frame

Behaviour:
- Interface decision: reset is reset, synchronous, active-high; clock is clk.
- States: IDLE, START, DATA, PARITY, STOP. A bit counter tracks data bits and stop bits. A baud counter runs 0..CLKS_PER_BIT-1.
- Reset values: state=IDLE, out=1, busy=0, done=0, in_ready=1. All counters and the shift register are cleared.
- Reset mid-frame aborts the frame. out returns to 1 on the next cycle. No done pulse is produced, and the partially sent word is discarded.
- Acceptance occurs when in_valid & in_ready at a clock edge. in_data is latched into the shift register at that edge. The parity bit is computed from the latched word.
- Later changes to in_data have no effect on the frame in progress.
- Latency: if a word is accepted at edge k, out=0 (start bit) during the cycle after edge k.
- Each bit is held on out for exactly CLKS_PER_BIT cycles.
- Bit order is START(0), then d[0]..d[DATA_BITS-1], then PARITY (if enabled), then STOP(1) x STOP_BITS.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity bit value:
  - Odd parity: parity bit = ~^data, so the count of ones in data plus parity is odd.
  - Even parity: parity bit = ^data.
- Transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after the last data bit if PARITY_EN, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE after the last cycle of the last stop bit, unless a word is accepted in that cycle.
  - STOP -> START when a word is accepted in the last cycle of the last stop bit.
- in_ready = (state==IDLE) | (state==STOP and this is the last cycle of the last stop bit). This allows back-to-back frames with zero idle gap: the start bit directly follows the stop bit.
- in_ready is low in all other cycles. in_valid is ignored while in_ready=0, and the producer must hold in_valid/in_data until accepted.
- done is high for exactly the last cycle of the last stop bit (the same cycle as the back-to-back in_ready window). It is low at all other times, including on abort.
- busy is high in START/DATA/PARITY/STOP. It remains high across a back-to-back handoff.
- out is driven from a register, so it is glitch-free; in IDLE it is 1.

Test Plan:
- Default params, reset, then send 0xA5 → out from the cycle after acceptance = 0,1,0,1,0,0,1,0,1,1; done=1 only in the 10th cycle; busy=1 for 10 cycles; in_ready=0 in cycles 1–9.
- Back-to-back: in_valid held high with 0x00 then 0xFF → out = 0,0×8,1 then immediately 0,1×8,1 with no idle cycle; done pulses at cycles 10 and 20; busy stays 1 for 20 cycles.
- PARITY_EN=1, PARITY_ODD=1, send 0x03 → 11-bit frame 0,1,1,0,0,0,0,0,0,1(parity),1; with PARITY_ODD=0 the parity bit = 0.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x80 → start low for 4 cycles, seven 0s for 28 cycles, then 1 for 12 cycles; frame = 44 cycles; done only in cycle 44.
- Assert reset in the 5th cycle of a 0xFF frame → out=1, busy=0, in_ready=1 on the next cycle, no done pulse; the next frame 0x5A transmits correctly.
- Change in_data and pulse in_valid mid-frame → frame bits unchanged, no extra acceptance; the word presented when in_ready returns is sent.
